// File: rtl/gcd_pkg.sv
// Shared state encoding, default sizes and tag-width helper for the GCD arbiter slice.
package gcd_pkg;

  localparam int GCD_W    = 16;
  localparam int GCD_NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/gcd_arb_ctrl_if.sv
// Requester/response bundle of the GCD arbiter; result_bits_iters exists only with GCD_ITER_COUNT_EN.
interface gcd_arb_ctrl_if
  import gcd_pkg::*;
#(
  parameter int W    = GCD_W,
  parameter int NREQ = GCD_NREQ
) ();
  localparam int TW = clog2(NREQ);

  logic [NREQ-1:0]   req_val;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ*W-1:0] operands_bits_A;
  logic [NREQ*W-1:0] operands_bits_B;
  logic              result_rdy;
  logic [W-1:0]      result_bits_data;
  logic [TW-1:0]     result_bits_tag;
  logic              result_taken;
  logic              busy;
`ifdef GCD_ITER_COUNT_EN
  logic [W-1:0]      result_bits_iters;
`endif

  modport master (
    output req_val, operands_bits_A, operands_bits_B, result_taken,
`ifdef GCD_ITER_COUNT_EN
    input  result_bits_iters,
`endif
    input  req_rdy, result_rdy, result_bits_data, result_bits_tag, busy
  );

  modport slave (
    input  req_val, operands_bits_A, operands_bits_B, result_taken,
`ifdef GCD_ITER_COUNT_EN
    output result_bits_iters,
`endif
    output req_rdy, result_rdy, result_bits_data, result_bits_tag, busy
  );

endinterface

// File: rtl/gcd_dpath.sv
// Operand registers plus compare/subtract arithmetic of the shared GCD engine.
// One load, swap or subtract per cycle; no flow control of its own.
module gcd_dpath #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         swap,
  input  logic         sub,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [W-1:0] a_val,
  output logic         a_lt_b,
  output logic         b_nz
);

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
    end else if (swap) begin
      a_q <= b_q;
      b_q <= a_q;
    end else if (sub) begin
      a_q <= a_q - b_q;
    end
  end

  assign a_val  = a_q;
  assign a_lt_b = (a_q < b_q);
  assign b_nz   = |b_q;

endmodule

// File: rtl/gcd_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one GCD engine; result k+2 cycles after grant,
// held in DONE until result_taken. GCD_ITER_COUNT_EN adds result_bits_iters.
module gcd_arb_ctrl
  import gcd_pkg::*;
#(
  parameter int W    = GCD_W,
  parameter int NREQ = GCD_NREQ
) (
  input logic           clk,
  input logic           reset,
  gcd_arb_ctrl_if.slave io
);

  localparam int TW = clog2(NREQ);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_CALC = CALC;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]      state;
  logic [TW-1:0]   ptr;
  logic [TW-1:0]   tag;
  logic [NREQ-1:0] grant;
  logic [TW-1:0]   grant_idx;
  logic            grant_any;
  logic            is_idle;
  logic            is_calc;
  logic            is_done;
  logic            hs;
  logic            do_swap;
  logic            do_sub;
  logic            fin;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [W-1:0]    a_val;
  logic            a_lt_b;
  logic            b_nz;

  // First requester at or after ptr, wrapping once around.
  always_comb begin : rr_pick
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && io.req_val[idx]) begin
        grant_any      = 1'b1;
        grant_idx      = TW'(idx);
        grant[idx]     = 1'b1;
      end
    end
  end

  assign is_idle = (state == S_IDLE);
  assign is_calc = (state == S_CALC);
  assign is_done = (state == S_DONE);
  assign hs      = is_idle & grant_any;

  assign a_sel = io.operands_bits_A[int'(grant_idx) * W +: W];
  assign b_sel = io.operands_bits_B[int'(grant_idx) * W +: W];

  assign do_swap = is_calc & a_lt_b;
  assign do_sub  = is_calc & ~a_lt_b & b_nz;
  assign fin     = is_calc & ~a_lt_b & ~b_nz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      tag   <= '0;
    end else begin
      case (state)
        S_IDLE: if (hs) begin
          state <= S_CALC;
          tag   <= grant_idx;
          ptr   <= (grant_idx == TW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        S_CALC: if (fin) state <= S_DONE;
        S_DONE: if (io.result_taken) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  gcd_dpath #(.W(W)) u_dpath (
    .clk    (clk),
    .reset  (reset),
    .load   (hs),
    .swap   (do_swap),
    .sub    (do_sub),
    .a_in   (a_sel),
    .b_in   (b_sel),
    .a_val  (a_val),
    .a_lt_b (a_lt_b),
    .b_nz   (b_nz)
  );

  // Grant is masked during reset so nothing can be accepted while state is cleared.
  assign io.req_rdy          = (is_idle && reset) ? grant : '0;
  assign io.result_rdy       = is_done;
  assign io.result_bits_data = is_done ? a_val : '0;
  assign io.result_bits_tag  = is_done ? tag : '0;
  assign io.busy             = ~is_idle;

`ifdef GCD_ITER_COUNT_EN
  logic [W-1:0] iters;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iters <= '0;
    end else if (hs) begin
      iters <= '0;
    end else if ((do_swap || do_sub) && (iters != '1)) begin
      iters <= iters + 1'b1;
    end
  end

  assign io.result_bits_iters = is_done ? iters : '0;
`else
  // Step counter not built.
`endif

endmodule

// File: tb/tb_gcd_arb_ctrl.sv
// Randomized and directed bench for gcd_arb_ctrl against a transaction-level reference model.
module tb_gcd_arb_ctrl;
  import gcd_pkg::*;

  localparam int W    = 16;
  localparam int NREQ = 4;
  localparam int SAT  = (1 << W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  gcd_arb_ctrl_if #(.W(W), .NREQ(NREQ)) io ();
  gcd_arb_ctrl #(.W(W), .NREQ(NREQ)) dut (.clk(clk), .reset(reset), .io(io));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0d expected=%0d t=%0t", name, act, exp, $time);
  endtask

  function automatic int rr_idx(input logic [NREQ-1:0] v, input int p);
    for (int off = 0; off < NREQ; off++)
      if (v[(p + off) % NREQ]) return (p + off) % NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] gcd_val(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = int'(a); y = int'(b);
    while (y != 0) begin t = x % y; x = y; y = t; end
    return W'(x);
  endfunction

  // Swap/subtract step count in closed form: each run of subtractions is a quotient.
  function automatic int gcd_steps(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t, k;
    x = int'(a); y = int'(b); k = 0;
    while (x < y || y != 0) begin
      if (x < y) begin t = x; x = y; y = t; k++; end
      else begin k += x / y; x = x % y; end
    end
    return k;
  endfunction

  // Reference model: one job in flight, result visible k+2 cycles after grant.
  logic            m_idle, m_done;
  int              m_ptr, m_cnt, m_tag, m_k, m_g, m_gi;
  logic [W-1:0]    m_res, m_a, m_b;
  logic [NREQ-1:0] m_gnt;

  always_comb begin
    m_g   = rr_idx(io.req_val, m_ptr);
    m_gi  = (m_g < 0) ? 0 : m_g;
    m_a   = io.operands_bits_A[m_gi*W +: W];
    m_b   = io.operands_bits_B[m_gi*W +: W];
    m_gnt = '0;
    if (m_idle && m_g >= 0) m_gnt[m_gi] = 1'b1;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_idle <= 1'b1; m_done <= 1'b0; m_ptr <= 0; m_cnt <= 0;
      m_tag <= 0; m_k <= 0; m_res <= '0;
    end else if (m_idle) begin
      if (m_g >= 0) begin
        m_idle <= 1'b0;
        m_tag  <= m_g;
        m_ptr  <= (m_g + 1) % NREQ;
        m_res  <= gcd_val(m_a, m_b);
        m_k    <= gcd_steps(m_a, m_b);
        m_cnt  <= gcd_steps(m_a, m_b) + 1;
      end
    end else if (!m_done) begin
      if (m_cnt == 1) m_done <= 1'b1;
      m_cnt <= m_cnt - 1;
    end else if (io.result_taken) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_req_rdy", io.req_rdy, '0);
      chk("rst_result_rdy", io.result_rdy, 0);
      chk("rst_data", io.result_bits_data, 0);
      chk("rst_tag", io.result_bits_tag, 0);
      chk("rst_busy", io.busy, 0);
    end else begin
      chk("req_rdy", io.req_rdy, m_gnt);
      chk("busy", io.busy, !m_idle);
      chk("result_rdy", io.result_rdy, m_done);
      if (m_done) begin
        chk("data", io.result_bits_data, m_res);
        chk("tag", io.result_bits_tag, m_tag);
`ifdef GCD_ITER_COUNT_EN
        chk("iters", io.result_bits_iters, (m_k > SAT) ? SAT : m_k);
`endif
      end
    end
  end

  task automatic set_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    io.operands_bits_A[r*W +: W] = a;
    io.operands_bits_B[r*W +: W] = b;
  endtask

  task automatic run_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output int tg, output int lat,
                        output logic [W-1:0] it);
    int n, hs_c;
    d = '0; tg = -1; lat = -1; it = '0;
    set_op(r, a, b);
    io.req_val = NREQ'(1) << r;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (io.req_rdy[r]) break;
    end
    chk("grant_wait", n < 50, 1);
    hs_c = cyc;
    @(posedge clk); #2;
    io.req_val = '0;
    for (n = 0; n < 70000; n++) begin
      @(negedge clk);
      if (io.result_rdy) break;
    end
    chk("result_wait", n < 70000, 1);
    lat = cyc - hs_c;
    d   = io.result_bits_data;
    tg  = int'(io.result_bits_tag);
`ifdef GCD_ITER_COUNT_EN
    it  = io.result_bits_iters;
`endif
    io.result_taken = 1'b1;
    @(posedge clk); #2;
    io.result_taken = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    io.result_taken = 1'b1;
    for (n = 0; n < 70000; n++) begin
      @(negedge clk);
      if (!io.busy) break;
    end
    chk("idle_wait", n < 70000, 1);
    @(posedge clk); #2;
    io.result_taken = 1'b0;
  endtask

  task automatic collect(input int want, output int ids[8], output int at[8], output int got);
    got = 0;
    for (int c = 0; c < 400 && got < want; c++) begin
      @(negedge clk);
      if (|(io.req_rdy & io.req_val)) begin
        for (int i = 0; i < NREQ; i++) if (io.req_rdy[i]) ids[got] = i;
        at[got] = cyc;
        got++;
      end
    end
    chk("grant_count", got, want);
  endtask

  logic [W-1:0] d, it;
  int tg, lat, got, n;
  int ids[8];
  int at[8];

  initial begin
    io.req_val = '0;
    io.operands_bits_A = '0;
    io.operands_bits_B = '0;
    io.result_taken = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    run_op(0, 16'd12, 16'd8, d, tg, lat, it);
    chk("t12_8_lat", lat, 7);
    chk("t12_8_data", d, 4);
    chk("t12_8_tag", tg, 0);
`ifdef GCD_ITER_COUNT_EN
    chk("t12_8_iters", it, 5);
`endif
    run_op(1, 16'd0, 16'd0, d, tg, lat, it);
    chk("t0_0_data", d, 0);
    chk("t0_0_lat", lat, 2);
    run_op(2, 16'd0, 16'd9, d, tg, lat, it);
    chk("t0_9_data", d, 9);
    chk("t0_9_tag", tg, 2);
    run_op(3, 16'd9, 16'd0, d, tg, lat, it);
    chk("t9_0_data", d, 9);
    run_op(0, 16'd65535, 16'd1, d, tg, lat, it);
    chk("tmax_1_data", d, 1);
`ifdef GCD_ITER_COUNT_EN
    chk("tmax_1_iters", it, 65535);
`endif

    // Result held un-taken for 10 cycles while everyone is requesting.
    set_op(0, 16'd5, 16'd10);
    io.req_val = 4'b0001;
    for (n = 0; n < 50; n++) begin @(negedge clk); if (io.req_rdy[0]) break; end
    chk("hold_grant_wait", n < 50, 1);
    @(posedge clk); #2;
    io.req_val = '1;
    for (n = 0; n < 200; n++) begin @(negedge clk); if (io.result_rdy) break; end
    chk("hold_result_wait", n < 200, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_data", io.result_bits_data, 5);
      chk("hold_tag", io.result_bits_tag, 0);
      chk("hold_req_rdy", io.req_rdy, '0);
    end
    io.result_taken = 1'b1;
    @(posedge clk); #2;
    io.result_taken = 1'b0;
    io.req_val = '0;

    // Reset in the middle of a (48,18) computation owned by requester 2.
    set_op(2, 16'd48, 16'd18);
    io.req_val = 4'b0100;
    for (n = 0; n < 50; n++) begin @(negedge clk); if (io.req_rdy[2]) break; end
    chk("rst_grant_wait", n < 50, 1);
    @(posedge clk); #2;
    io.req_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", io.busy, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", io.busy, 0);
    chk("mid_rst_rdy", io.result_rdy, 0);
    chk("mid_rst_data", io.result_bits_data, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    io.req_val = '1;
    @(negedge clk);
    chk("post_rst_grant", io.req_rdy, 4'b0001);
    @(posedge clk); #2;
    io.req_val = '0;
    wait_idle();

    // All four requesting with result_taken high: strict rotation from ptr 0.
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'd6, 16'd4);
    io.result_taken = 1'b1;
    io.req_val = '1;
    collect(5, ids, at, got);
    chk("rr_0", ids[0], 0);
    chk("rr_1", ids[1], 1);
    chk("rr_2", ids[2], 2);
    chk("rr_3", ids[3], 3);
    chk("rr_4", ids[4], 0);
    chk("rr_gap", at[1] - at[0], 8);
    @(posedge clk); #2;
    io.req_val = '0;
    wait_idle();

    // Move ptr to 2, then requesters 1 and 3 contend.
    for (int i = 0; i < NREQ; i++) set_op(i, 16'd3, 16'd3);
    io.result_taken = 1'b1;
    io.req_val = 4'b0010;
    collect(1, ids, at, got);
    chk("p2_first", ids[0], 1);
    @(posedge clk); #2;
    io.req_val = 4'b1010;
    collect(2, ids, at, got);
    chk("p2_a", ids[0], 3);
    chk("p2_b", ids[1], 1);
    @(posedge clk); #2;
    io.req_val = '0;
    wait_idle();

    // Random traffic: requesters come and go, consumer stalls at random.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #2;
      for (int i = 0; i < NREQ; i++) begin
        io.req_val[i] = ($urandom_range(0, 2) != 0);
        set_op(i, W'($urandom_range(0, 40)), W'($urandom_range(0, 40)));
      end
      io.result_taken = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk); #2;
    io.req_val = '0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
